// File: rtl/fpu_norm_round.sv
// Normalise / round-to-nearest-even / pack stage behind the FPU datapath, single-entry buffered.
// Define FPU_SUBNORMAL_EN to emit subnormals; otherwise tiny results flush to signed zero.
module fpu_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_special,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [MAN_W+4:0]       in_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [2:0]             errors
);

  localparam int RES_W = EXP_W + MAN_W + 1;
  localparam int MW    = MAN_W + 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [1:0]              state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [MW-1:0]           man_q, man_d;
  logic [RES_W-1:0]        out_q, out_d;
  logic [2:0]              err_q, err_d;

  // One-bit shifts; right shift folds the dropped bits into sticky
  logic [MW-1:0] shr, shl;
  assign shr = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
  assign shl = {man_q[MW-2:0], 1'b0};

  logic                    exp_lo, inc, inx, tiny, ovf;
  logic [MAN_W+1:0]        sum;
  logic signed [EXP_W+1:0] exp_r;
  logic [EXP_W-1:0]        exp_enc;
  logic [MAN_W-1:0]        frac_r;

  assign exp_lo  = exp_q < EXP_ONE;
  assign inc     = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
  assign inx     = man_q[2] | man_q[1] | man_q[0];
  assign tiny    = ~man_q[MW-2];
  assign sum     = {1'b0, man_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
  assign exp_r   = sum[MAN_W+1] ? exp_q + EXP_ONE : exp_q;
  // A significand without its hidden bit after rounding is encoded as a subnormal
  assign exp_enc = (sum[MAN_W+1] | sum[MAN_W]) ? exp_r[EXP_W-1:0] : '0;
  assign frac_r  = sum[MAN_W+1] ? '0 : sum[MAN_W-1:0];
  assign ovf     = exp_r >= EXP_MAX;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = $signed(in_exp);
          man_d  = in_man;
          err_d  = '0;
          state_d = S_OUT;
          case (in_special)
            2'b00:   state_d = S_NORM;
            2'b01:   out_d = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            2'b10:   out_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            default: out_d = {in_sign, {(RES_W-1){1'b0}}};
          endcase
        end
      end
      S_NORM: begin
        if (man_q == '0) begin
          out_d   = {sign_q, {(RES_W-1){1'b0}}};
          err_d   = '0;
          state_d = S_OUT;
        end else if (man_q[MW-1]) begin
          man_d   = shr;
          exp_d   = exp_q + EXP_ONE;
          state_d = S_ROUND;
        end else if (exp_lo) begin
`ifdef FPU_SUBNORMAL_EN
          man_d = shr;
          exp_d = exp_q + EXP_ONE;
`else
          out_d   = {sign_q, {(RES_W-1){1'b0}}};
          err_d   = 3'b011;
          state_d = S_OUT;
`endif
        end else if (!man_q[MW-2] && exp_q > EXP_ONE) begin
          man_d = shl;
          exp_d = exp_q - EXP_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = S_OUT;
`ifdef FPU_SUBNORMAL_EN
        if (exp_lo) begin
          out_d = {sign_q, {(RES_W-1){1'b0}}};
          err_d = 3'b011;
        end else if (ovf) begin
          out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          err_d = 3'b101;
        end else begin
          out_d = {sign_q, exp_enc, frac_r};
          err_d = {1'b0, tiny & inx, inx};
        end
`else
        if (exp_lo || tiny) begin
          out_d = {sign_q, {(RES_W-1){1'b0}}};
          err_d = 3'b011;
        end else if (ovf) begin
          out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          err_d = 3'b101;
        end else begin
          out_d = {sign_q, exp_enc, frac_r};
          err_d = {2'b00, inx};
        end
`endif
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = state_q == S_OUT;
  assign out       = out_q;
  assign errors    = err_q;

endmodule
